// File: rtl/bmem_line_adapter.sv
// Cache-line <-> 64-bit burst memory adapter: fill = one read command + BURST_LEN tagged beats, writeback = BURST_LEN beats.
// Latency: read 1 + mem latency + BURST_LEN + 1, write BURST_LEN + 1; bmem_ready=0 holds command/beat, line_busy blocks cache side.
module bmem_line_adapter #(
  parameter int BURST_LEN = 4,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          line_addr,
  input  logic                 line_read,
  input  logic                 line_write,
  input  logic [LINE_BITS-1:0] line_wdata,
  output logic [LINE_BITS-1:0] line_rdata,
  output logic                 line_resp,
  output logic                 line_busy,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [63:0]          bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [63:0]          bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    line_resp  = 1'b0;
    line_busy  = 1'b1;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;

    case (state_q)
      IDLE: begin
        line_busy = 1'b0;
        // Writeback wins so a dirty victim is never lost behind its refill.
        if (line_write || line_read) begin
          addr_d  = line_addr & ~32'h1F;
          wdata_d = line_wdata;
          cnt_d   = '0;
          state_d = line_write ? WR_BURST : RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats tagged with another address belong to an abandoned burst.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          rdata_d[cnt_q*64 +: 64] = bmem_rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wdata_q[cnt_q*64 +: 64];
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_rdata = rdata_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Bench for bmem_line_adapter: directed scenarios plus randomized fills/writebacks against a line-level memory model.
module tb_bmem_line_adapter;
  localparam int BL = 4;
  localparam int LB = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   line_addr;
  logic          line_read, line_write;
  logic [LB-1:0] line_wdata, line_rdata;
  logic          line_resp, line_busy;
  logic [31:0]   bmem_addr;
  logic          bmem_read, bmem_write;
  logic [63:0]   bmem_wdata;
  logic          bmem_ready;
  logic [31:0]   bmem_raddr;
  logic [63:0]   bmem_rdata;
  logic          bmem_rvalid;

  always #5 clk = ~clk;

  bmem_line_adapter #(.BURST_LEN(BL), .LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .line_busy(line_busy), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int checks = 0;
  int failures = 0;

  int          rd_hi, rd_acc, wr_hi, resp_cnt, both_hi, wr_addr_bad;
  logic [31:0] rd_acc_addr, exp_wr_addr;
  logic [63:0] wr_acc_q[$];
  logic [63:0] wr_cyc_q[$];
  logic [LB-1:0] exp_last_line;

  task automatic clr();
    rd_hi = 0; rd_acc = 0; wr_hi = 0; resp_cnt = 0; both_hi = 0; wr_addr_bad = 0;
    rd_acc_addr = '0;
    wr_acc_q.delete();
    wr_cyc_q.delete();
  endtask

  // One clock: observe the bus mid-cycle, then advance to just after the next edge.
  task automatic cyc();
    @(negedge clk);
    if (bmem_read) rd_hi++;
    if (bmem_read && bmem_ready) begin rd_acc++; rd_acc_addr = bmem_addr; end
    if (bmem_write) begin
      wr_hi++;
      wr_cyc_q.push_back(bmem_wdata);
      if (bmem_addr !== exp_wr_addr) wr_addr_bad++;
      if (bmem_ready) wr_acc_q.push_back(bmem_wdata);
    end
    if (line_resp) resp_cnt++;
    if (bmem_read && bmem_write) both_hi++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] ra, input logic [63:0] d);
    line_read = 1'b0; line_write = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = ra; bmem_rdata = d;
    cyc();
    bmem_rvalid = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [LB-1:0] line,
                         input bit junk, input bit gaps, input bit stall, input bit noise);
    logic [31:0] ea, ja;
    int n;
    ea = {addr[31:5], 5'b0};
    ja = (ea == 32'h2000) ? 32'h4000 : 32'h2000;
    clr();
    line_addr = addr; line_read = 1'b1; line_write = 1'b0; bmem_ready = 1'b1;
    cyc();
    line_read = 1'b0;
    checks++;
    if (!(bmem_read === 1'b1 && bmem_addr === ea && bmem_write === 1'b0 && line_busy === 1'b1)) begin
      failures++;
      $display("FAIL fill_cmd: read=%b addr=%h write=%b busy=%b, want 1 %h 0 1", bmem_read, bmem_addr, bmem_write, line_busy, ea);
    end
    n = 0;
    while (rd_acc == 0 && n < 50) begin
      bmem_ready = (stall && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
      cyc();
    end
    checks++;
    if (rd_acc !== 1 || rd_acc_addr !== ea) begin
      failures++;
      $display("FAIL fill_cmd_accept: accepted=%0d addr=%h, want 1 %h", rd_acc, rd_acc_addr, ea);
    end
    for (int k = 0; k < BL; k++) begin
      int g;
      g = gaps ? $urandom_range(0, 2) : 0;
      if (junk && (k == 1 || k == 2)) g = g + 1;
      for (int j = 0; j < g; j++) begin
        if (noise) begin
          line_read = 1'($urandom_range(0, 1)); line_write = 1'($urandom_range(0, 1));
          line_addr = $urandom;
        end
        if (junk && j == 0) begin
          bmem_rvalid = 1'b1; bmem_raddr = ja; bmem_rdata = {$urandom, $urandom};
        end
        bmem_ready = 1'($urandom_range(0, 1));
        cyc();
        bmem_rvalid = 1'b0;
      end
      send_beat(ea, line[64*k +: 64]);
    end
    checks++;
    if (line_resp !== 1'b1 || line_rdata !== line) begin
      failures++;
      $display("FAIL fill_resp: resp=%b rdata=%h, want 1 %h", line_resp, line_rdata, line);
    end
    cyc();
    checks++;
    if (line_resp !== 1'b0 || line_busy !== 1'b0 || resp_cnt !== 1 || line_rdata !== line) begin
      failures++;
      $display("FAIL fill_end: resp=%b busy=%b pulses=%0d rdata=%h, want 0 0 1 %h", line_resp, line_busy, resp_cnt, line_rdata, line);
    end
    checks++;
    if (rd_acc !== 1 || rd_hi !== n || wr_hi !== 0 || both_hi !== 0) begin
      failures++;
      $display("FAIL fill_bus: rd_acc=%0d rd_hi=%0d wr_hi=%0d both=%0d, want 1 %0d 0 0", rd_acc, rd_hi, wr_hi, both_hi, n);
    end
    exp_last_line = line;
  endtask

  // mode 0: ready always high, 1: two stall cycles on beat 1, 2: random ready.
  task automatic do_write(input logic [31:0] addr, input logic [LB-1:0] line, input bit both, input int mode);
    int t, stl, exp_t;
    clr();
    exp_wr_addr = {addr[31:5], 5'b0};
    line_addr = addr; line_wdata = line; line_write = 1'b1; line_read = both; bmem_ready = 1'b1;
    cyc();
    line_write = 1'b0; line_read = 1'b0;
    line_wdata = {8{$urandom}};
    t = 0; stl = 2;
    while (resp_cnt == 0 && t < 60) begin
      if (mode == 1) begin
        if (wr_acc_q.size() == 1 && stl > 0) begin bmem_ready = 1'b0; stl--; end
        else bmem_ready = 1'b1;
      end else if (mode == 2 && t < 40) begin
        bmem_ready = 1'($urandom_range(0, 1));
      end else begin
        bmem_ready = 1'b1;
      end
      t++;
      cyc();
    end
    checks++;
    if (resp_cnt !== 1 || line_busy !== 1'b0 || line_resp !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp: pulses=%0d busy=%b resp=%b, want 1 0 0", resp_cnt, line_busy, line_resp);
    end
    checks++;
    if (wr_acc_q.size() !== BL) begin
      failures++;
      $display("FAIL wr_beat_count: accepted=%0d, want %0d", wr_acc_q.size(), BL);
    end else begin
      for (int k = 0; k < BL; k++) begin
        checks++;
        if (wr_acc_q[k] !== line[64*k +: 64]) begin
          failures++;
          $display("FAIL wr_beat%0d: got %h want %h", k, wr_acc_q[k], line[64*k +: 64]);
        end
      end
    end
    checks++;
    if (wr_hi !== t - 1 || rd_hi !== 0 || both_hi !== 0 || wr_addr_bad !== 0) begin
      failures++;
      $display("FAIL wr_bus: wr_hi=%0d rd_hi=%0d both=%0d badaddr=%0d, want %0d 0 0 0", wr_hi, rd_hi, both_hi, wr_addr_bad, t - 1);
    end
    if (mode != 2) begin
      exp_t = (mode == 0) ? BL + 1 : BL + 3;
      checks++;
      if (t !== exp_t) begin
        failures++;
        $display("FAIL wr_latency: resp after %0d cycles, want %0d", t, exp_t);
      end
    end
    if (mode == 1) begin
      checks++;
      if (wr_cyc_q.size() !== 6 || wr_cyc_q[1] !== line[127:64] || wr_cyc_q[2] !== line[127:64] || wr_cyc_q[3] !== line[127:64]) begin
        failures++;
        $display("FAIL wr_hold: cycles=%0d, want 6 with beat1 %h held 3 cycles", wr_cyc_q.size(), line[127:64]);
      end
    end
    checks++;
    if (line_rdata !== exp_last_line) begin
      failures++;
      $display("FAIL wr_rdata_stable: got %h want %h", line_rdata, exp_last_line);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    exp_wr_addr = '0; exp_last_line = '0;
    clr();
    @(posedge clk); #1;
    cyc();
    checks++;
    if (line_rdata !== '0 || line_resp !== 1'b0 || line_busy !== 1'b0 || bmem_read !== 1'b0 ||
        bmem_write !== 1'b0 || bmem_addr !== '0 || bmem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_state: rdata=%h resp=%b busy=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
               line_rdata, line_resp, line_busy, bmem_read, bmem_write, bmem_addr, bmem_wdata);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_fill();
    do_fill(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_writeback();
    do_write(32'h0000_0080, {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                             64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 1'b0, 0);
  endtask

  task automatic test_write_backpressure();
    do_write(32'h0000_0080, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, 1);
  endtask

  task automatic test_filter();
    do_fill(32'h0000_1234, {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000}, 1'b1, 1'b0, 1'b0, 1'b0);
    do_write(32'h0000_0C1F, {4{$urandom, $urandom}}, 1'b1, 0);
  endtask

  task automatic test_reset_mid_fill();
    clr();
    line_addr = 32'h0000_1234; line_read = 1'b1; bmem_ready = 1'b1;
    cyc();
    line_read = 1'b0;
    cyc();
    send_beat(32'h0000_1220, 64'h1111_1111_1111_1111);
    send_beat(32'h0000_1220, 64'h2222_2222_2222_2222);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_last_line = '0;
    checks++;
    if (line_rdata !== '0 || line_resp !== 1'b0 || line_busy !== 1'b0 || bmem_read !== 1'b0 ||
        bmem_write !== 1'b0 || bmem_addr !== '0 || bmem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_mid_fill: rdata=%h resp=%b busy=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
               line_rdata, line_resp, line_busy, bmem_read, bmem_write, bmem_addr, bmem_wdata);
    end
    clr();
    send_beat(32'h0000_1220, 64'h3333_3333_3333_3333);
    send_beat(32'h0000_1220, 64'h4444_4444_4444_4444);
    cyc(); cyc();
    checks++;
    if (resp_cnt !== 0 || line_busy !== 1'b0 || line_rdata !== '0) begin
      failures++;
      $display("FAIL stale_beats: pulses=%0d busy=%b rdata=%h, want 0 0 0", resp_cnt, line_busy, line_rdata);
    end
    do_fill(32'h0000_5678, {4{$urandom, $urandom}}, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 14; i++) begin
      logic [31:0]   a;
      logic [LB-1:0] l;
      a = $urandom;
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0: do_fill(a, l, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        1: do_write(a, l, 1'b0, 2);
        default: do_write(a, l, 1'b1, ($urandom_range(0, 1) == 1) ? 2 : 0);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_write_backpressure();
    test_filter();
    test_reset_mid_fill();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
